// File: rtl/matrix_pkg.sv
// Shared types and defaults for the matrix load scheduler.
// Optional feature macro: SCHED_TIMEOUT_EN (adds the ABORT state).
package matrix_pkg;

    localparam int unsigned DIM_DEF   = 4;
    localparam int unsigned WIDTH_DEF = 77;

    // Scheduler states; ABORT only exists when the stall timeout is built in.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COLEN,
        COMPUTE,
        DONE
`ifdef SCHED_TIMEOUT_EN
        , ABORT
`endif
    } sched_state_e;

endpackage

// File: rtl/matrix_load_sched_if.sv
// Requester and array-side signals of the matrix load scheduler.
interface matrix_load_sched_if
    import matrix_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DIM   = DIM_DEF
);
    logic [NREQ-1:0]       req_v_i;
    logic [NREQ*WIDTH-1:0] req_data_i;
    logic [NREQ-1:0]       req_r_o;
    logic [NREQ-1:0]       grant_o;
    logic [WIDTH-1:0]      row_data_o;
    logic                  row_v_o;
    logic [DIM-1:0]        col_en_o;
    logic                  busy_o;
    logic [NREQ-1:0]       done_o;
    logic                  err_o;

    modport master (
        output req_v_i, req_data_i,
        input  req_r_o, grant_o, row_data_o, row_v_o, col_en_o, busy_o, done_o, err_o
    );

    modport slave (
        input  req_v_i, req_data_i,
        output req_r_o, grant_o, row_data_o, row_v_o, col_en_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);
    logic [PW-1:0] idx;
    logic          found;

    // Scan from ptr upward with wrap, grant the first set request.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PW'((32'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/matrix_load_sched.sv
// Matrix load scheduler: arbitrates requesters, streams DIM*DIM row words
// into the array, pulses column enables, waits out compute, signals done.
// Optional feature macro: SCHED_TIMEOUT_EN (stall timeout with ABORT state).
module matrix_load_sched
    import matrix_pkg::*;
#(
    parameter int unsigned DIM         = DIM_DEF,
    parameter int unsigned WIDTH       = WIDTH_DEF,
    parameter int unsigned NREQ        = 2,
    parameter int unsigned COMPUTE_CYC = 8,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    matrix_load_sched_if.slave  bus
);
    localparam int unsigned CW = $clog2(DIM + 1);
    localparam int unsigned YW = $clog2(COMPUTE_CYC + 1);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || COMPUTE_CYC < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("matrix_load_sched: illegal parameter set");
    end

    sched_state_e    state;
    logic [CW-1:0]   word_cnt;
    logic [CW-1:0]   col_cnt;
    logic [YW-1:0]   cyc_cnt;
    logic [NREQ-1:0] grant_q;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_next;
    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic [DIM-1:0]  col_en_q;
    logic [NREQ-1:0] done_q;
    logic            busy_q;
    logic            load_rdy;
    logic            hs;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req (bus.req_v_i),
        .ptr (rr_ptr),
        .gnt (arb_gnt)
    );

    // One-hot arbiter grant to an index for data muxing.
    always_comb begin
        arb_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) arb_idx = PW'(i);
        end
    end

    // Next round-robin start: the requester after the current owner.
    always_comb begin
        rr_next = grant_idx + PW'(1);
        if (32'(grant_idx) == NREQ - 1) rr_next = '0;
    end

    // Owner word accepted this cycle; drives the array with zero latency.
    always_comb begin
        load_rdy = (state == LOAD) && (word_cnt < CW'(DIM));
        hs       = load_rdy && bus.req_v_i[grant_idx];
    end

    assign bus.req_r_o    = load_rdy ? grant_q : '0;
    assign bus.row_v_o    = hs;
    assign bus.row_data_o = hs ? bus.req_data_i[32'(grant_idx) * WIDTH +: WIDTH] : '0;
    assign bus.grant_o    = grant_q;
    assign bus.col_en_o   = col_en_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;

`ifdef SCHED_TIMEOUT_EN
    localparam int unsigned SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_cnt;
    logic          err_q;
    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    // Scheduler FSM with its counters and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            word_cnt  <= '0;
            col_cnt   <= '0;
            cyc_cnt   <= '0;
            grant_q   <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
            col_en_q  <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            stall_cnt <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_v_i) begin
                        state     <= LOAD;
                        grant_q   <= arb_gnt;
                        grant_idx <= arb_idx;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        word_cnt <= word_cnt + CW'(1);
                        if (word_cnt == CW'(DIM - 1)) begin
                            state    <= COLEN;
                            col_en_q <= DIM'(1) << col_cnt;
                        end
`ifdef SCHED_TIMEOUT_EN
                        stall_cnt <= '0;
                    end else if (stall_cnt == SW'(TIMEOUT - 1)) begin
                        state     <= ABORT;
                        err_q     <= 1'b1;
                        stall_cnt <= '0;
                        word_cnt  <= '0;
                        col_cnt   <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + SW'(1);
`endif
                    end
                end
                COLEN: begin
                    col_en_q <= '0;
                    col_cnt  <= col_cnt + CW'(1);
                    word_cnt <= '0;
                    state    <= (col_cnt == CW'(DIM - 1)) ? COMPUTE : LOAD;
                end
                COMPUTE: begin
                    if (cyc_cnt == YW'(COMPUTE_CYC - 1)) begin
                        state   <= DONE;
                        cyc_cnt <= '0;
                        col_cnt <= '0;
                        done_q  <= grant_q;
                    end else begin
                        cyc_cnt <= cyc_cnt + YW'(1);
                    end
                end
                DONE: begin
                    done_q    <= '0;
                    grant_q   <= '0;
                    grant_idx <= '0;
                    rr_ptr    <= rr_next;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
`ifdef SCHED_TIMEOUT_EN
                ABORT: begin
                    err_q     <= 1'b0;
                    grant_q   <= '0;
                    grant_idx <= '0;
                    rr_ptr    <= rr_next;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_load_sched.sv
// Self-checking bench for matrix_load_sched (scoreboarded row words).
module tb_matrix_load_sched;
    localparam int unsigned DIM         = 4;
    localparam int unsigned WIDTH       = 77;
    localparam int unsigned NREQ        = 2;
    localparam int unsigned COMPUTE_CYC = 8;
    localparam int unsigned TIMEOUT     = 64;
    localparam int          JOB_CYC     = DIM * DIM + DIM + COMPUTE_CYC + 1;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    matrix_load_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DIM(DIM)) bus ();

    matrix_load_sched #(
        .DIM(DIM), .WIDTH(WIDTH), .NREQ(NREQ),
        .COMPUTE_CYC(COMPUTE_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int               checks = 0;
    int               errors = 0;
    logic [NREQ-1:0]  vld;
    logic [WIDTH-1:0] cur_word [NREQ];
    int               hs_cnt [NREQ];
    logic [WIDTH-1:0] sb_q [$];

    function automatic logic [WIDTH-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[WIDTH-1:0];
    endfunction

    // Drive one cycle at the falling edge; push accepted words to the scoreboard.
    task automatic step(output logic [NREQ-1:0] hs);
        @(negedge clk_i);
        for (int r = 0; r < NREQ; r++) begin
            bus.req_v_i[r] = vld[r];
            bus.req_data_i[r*WIDTH +: WIDTH] = cur_word[r];
        end
        #1;
        hs = bus.req_v_i & bus.req_r_o;
        for (int r = 0; r < NREQ; r++) begin
            if (hs[r]) begin
                sb_q.push_back(cur_word[r]);
                hs_cnt[r]++;
                cur_word[r] = rand_word();
            end
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        vld = '0;
        bus.req_v_i = '0;
        bus.req_data_i = '0;
        sb_q.delete();
        hs_cnt = '{default: 0};
        for (int r = 0; r < NREQ; r++) cur_word[r] = rand_word();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        logic [WIDTH+64:0] obs;
        rst_ni = 1'b0;
        vld = '1;
        for (int r = 0; r < NREQ; r++) cur_word[r] = rand_word();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            bus.req_v_i = vld;
            for (int r = 0; r < NREQ; r++) bus.req_data_i[r*WIDTH +: WIDTH] = cur_word[r];
            #1;
            obs = {bus.grant_o, bus.req_r_o, bus.row_v_o, bus.row_data_o,
                   bus.col_en_o, bus.busy_o, bus.done_o, bus.err_o};
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h expected 0", obs);
            end
        end
        do_reset();
    endtask

    // One job from requester 0, optionally stalled after word 6, optionally
    // with requester 1 holding valid the whole time.
    task automatic test_load_job(input string name, input int stall_len, input bit other);
        logic [NREQ-1:0] hs;
        logic [DIM-1:0]  col_q [$];
        logic [DIM-1:0]  c;
        int cyc = 0;
        int done_cyc = 0;
        int stall_left;
        bit stalling;
        do_reset();
        for (int i = 0; i < DIM; i++) begin
            c = '0;
            c[i] = 1'b1;
            col_q.push_back(c);
        end
        stall_left = stall_len;
        vld = other ? 2'b11 : 2'b01;
        for (int t = 0; t < 200 && done_cyc == 0; t++) begin
            stalling = 1'b0;
            if (hs_cnt[0] == 6 && stall_left > 0) begin
                vld[0] = 1'b0;
                stall_left--;
                stalling = 1'b1;
            end else begin
                vld[0] = (hs_cnt[0] < DIM * DIM);
            end
            step(hs);
            if (cyc > 0 || bus.grant_o != '0) cyc++;
            if (cyc == 0) begin
                checks++;
                if (bus.req_r_o !== '0 || bus.row_v_o !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_ready: got %b/%b expected 00/0", name, bus.req_r_o, bus.row_v_o);
                end
                continue;
            end
            checks++;
            if (bus.grant_o !== 2'b01 || bus.busy_o !== 1'b1) begin
                errors++;
                $display("FAIL %s grant_busy: got %b/%b expected 01/1", name, bus.grant_o, bus.busy_o);
            end
            checks++;
            if (bus.req_r_o[1] !== 1'b0 || bus.err_o !== 1'b0) begin
                errors++;
                $display("FAIL %s nonowner_ready_err: got %b/%b expected 0/0", name, bus.req_r_o[1], bus.err_o);
            end
            checks++;
            if (bus.row_v_o !== hs[0]) begin
                errors++;
                $display("FAIL %s row_v: got %b expected %b (cycle %0d)", name, bus.row_v_o, hs[0], cyc);
            end
            if (bus.row_v_o === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s row_data: got %h expected none", name, bus.row_data_o);
                end else if (bus.row_data_o !== sb_q[0]) begin
                    errors++;
                    $display("FAIL %s row_data: got %h expected %h", name, bus.row_data_o, sb_q[0]);
                end
                if (sb_q.size() != 0) void'(sb_q.pop_front());
                if (other) begin
                    checks++;
                    if (bus.row_data_o === cur_word[1]) begin
                        errors++;
                        $display("FAIL %s leak: got %h expected owner data", name, bus.row_data_o);
                    end
                end
            end
            if (bus.col_en_o !== '0) begin
                checks++;
                if (bus.row_v_o !== 1'b0 || col_q.size() == 0 || bus.col_en_o !== col_q[0]) begin
                    errors++;
                    $display("FAIL %s col_en: got %b row_v %b expected %b", name, bus.col_en_o, bus.row_v_o,
                             (col_q.size() != 0) ? col_q[0] : 4'b0);
                end
                if (col_q.size() != 0) void'(col_q.pop_front());
            end
            if (stalling) begin
                checks++;
                if (bus.row_v_o !== 1'b0 || bus.col_en_o !== '0) begin
                    errors++;
                    $display("FAIL %s stall_hold: got row_v %b col_en %b expected 0/0", name, bus.row_v_o, bus.col_en_o);
                end
            end
            if (bus.done_o !== '0) begin
                done_cyc = cyc;
                checks++;
                if (bus.done_o !== 2'b01) begin
                    errors++;
                    $display("FAIL %s done_owner: got %b expected 01", name, bus.done_o);
                end
            end
        end
        checks++;
        if (done_cyc != JOB_CYC + stall_len) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, JOB_CYC + stall_len);
        end
        checks++;
        if (hs_cnt[0] != DIM * DIM || hs_cnt[1] != 0 || sb_q.size() != 0 || col_q.size() != 0) begin
            errors++;
            $display("FAIL %s counts: got hs %0d/%0d sb %0d col %0d expected 16/0/0/0",
                     name, hs_cnt[0], hs_cnt[1], sb_q.size(), col_q.size());
        end
        vld[0] = 1'b0;
        step(hs);
        checks++;
        if (bus.grant_o !== '0 || bus.busy_o !== 1'b0 || bus.done_o !== '0) begin
            errors++;
            $display("FAIL %s after_done: got %b/%b/%b expected 00/0/00", name, bus.grant_o, bus.busy_o, bus.done_o);
        end
        step(hs);
        checks++;
        if (bus.grant_o !== (other ? 2'b10 : 2'b00)) begin
            errors++;
            $display("FAIL %s next_grant: got %b expected %b", name, bus.grant_o, other ? 2'b10 : 2'b00);
        end
    endtask

    task automatic test_contention();
        logic [NREQ-1:0] hs;
        logic [NREQ-1:0] exp_q [$];
        logic [NREQ-1:0] prev_g;
        exp_q = '{2'b01, 2'b10, 2'b01};
        rst_ni = 1'b0;
        sb_q.delete();
        hs_cnt = '{default: 0};
        vld = 2'b11;
        @(negedge clk_i);
        bus.req_v_i = vld;
        @(negedge clk_i);
        rst_ni = 1'b1;
        prev_g = '0;
        for (int t = 0; t < 150 && exp_q.size() != 0; t++) begin
            step(hs);
            if (bus.row_v_o === 1'b1) begin
                checks++;
                if (sb_q.size() == 0 || bus.row_data_o !== sb_q[0]) begin
                    errors++;
                    $display("FAIL contention_row_data: got %h expected %h", bus.row_data_o,
                             (sb_q.size() != 0) ? sb_q[0] : '0);
                end
                if (sb_q.size() != 0) void'(sb_q.pop_front());
            end
            if (bus.grant_o !== prev_g && bus.grant_o !== '0) begin
                checks++;
                if (bus.grant_o !== exp_q[0]) begin
                    errors++;
                    $display("FAIL contention_grant: got %b expected %b", bus.grant_o, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            prev_g = bus.grant_o;
        end
        checks++;
        if (exp_q.size() != 0 || hs_cnt[0] < DIM * DIM || hs_cnt[1] != DIM * DIM) begin
            errors++;
            $display("FAIL contention_progress: got %0d grants left, hs %0d/%0d expected 0, >=16/16",
                     exp_q.size(), hs_cnt[0], hs_cnt[1]);
        end
    endtask

    task automatic test_reset_mid_job();
        logic [NREQ-1:0]   hs;
        logic [WIDTH+64:0] obs;
        int ncol = 0;
        do_reset();
        vld = 2'b01;
        for (int t = 0; t < 60 && ncol < DIM; t++) begin
            if (hs_cnt[0] >= DIM * DIM) vld[0] = 1'b0;
            step(hs);
            if (bus.col_en_o !== '0) ncol++;
        end
        repeat (3) step(hs);
        checks++;
        if (ncol != DIM || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_compute: got cols %0d busy %b expected 4/1", ncol, bus.busy_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        obs = {bus.grant_o, bus.req_r_o, bus.row_v_o, bus.row_data_o,
               bus.col_en_o, bus.busy_o, bus.done_o, bus.err_o};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL midreset_async: got %h expected 0", obs);
        end
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        vld = '0;
        for (int t = 0; t < 40; t++) begin
            step(hs);
            checks++;
            if (bus.done_o !== '0 || bus.busy_o !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_done: got %b/%b expected 00/0", bus.done_o, bus.busy_o);
            end
        end
        vld = 2'b11;
        step(hs);
        step(hs);
        checks++;
        if (bus.grant_o !== 2'b01) begin
            errors++;
            $display("FAIL midreset_regrant: got %b expected 01", bus.grant_o);
        end
    endtask

`ifdef SCHED_TIMEOUT_EN
    task automatic test_timeout();
        logic [NREQ-1:0] hs;
        int silent = 0;
        int err_at = 0;
        do_reset();
        vld = 2'b11;
        for (int t = 0; t < 120 && err_at == 0; t++) begin
            if (hs_cnt[0] >= 3) vld[0] = 1'b0;
            step(hs);
            if (bus.grant_o === 2'b01 && !vld[0]) silent++;
            if (bus.err_o === 1'b1) err_at = silent;
            checks++;
            if (bus.done_o !== '0) begin
                errors++;
                $display("FAIL timeout_no_done: got %b expected 00", bus.done_o);
            end
        end
        checks++;
        if (err_at != TIMEOUT + 1) begin
            errors++;
            $display("FAIL timeout_err_cycle: got %0d expected %0d", err_at, TIMEOUT + 1);
        end
        step(hs);
        checks++;
        if (bus.err_o !== 1'b0 || bus.grant_o !== '0) begin
            errors++;
            $display("FAIL timeout_after: got err %b grant %b expected 0/00", bus.err_o, bus.grant_o);
        end
        step(hs);
        checks++;
        if (bus.grant_o !== 2'b10) begin
            errors++;
            $display("FAIL timeout_next_grant: got %b expected 10", bus.grant_o);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vld = '0;
        bus.req_v_i = '0;
        bus.req_data_i = '0;
        test_reset();
        test_load_job("single", 0, 1'b0);
        test_load_job("stall", 5, 1'b0);
        test_load_job("isolation", 0, 1'b1);
        test_contention();
        test_reset_mid_job();
`ifdef SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_load_sched.md
MATRIX_LOAD_SCHED -- requirements
Module: matrix_load_sched

Interface
REQ-001 Parameter DIM, 4, matrix dimension: words per column and number of columns.
REQ-002 Parameter WIDTH, 77, row-word width in bits.
REQ-003 Parameter NREQ, 2, number of requesters (>=2).
REQ-004 Parameter COMPUTE_CYC, 8, array compute latency in cycles after the last column enable (>=1).
REQ-005 Parameter TIMEOUT, 64, stall limit in cycles (used only under SCHED_TIMEOUT_EN).
REQ-006 clk_i  in  1  single clock, rising edge.
REQ-007 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-008 req_v_i  in  NREQ  per-requester word valid; also serves as the job request.
REQ-009 req_data_i  in  NREQ*WIDTH  per-requester row word, packed with requester 0 in the LSBs.
REQ-010 req_r_o  out  NREQ  per-requester ready; at most one bit set.
REQ-011 grant_o  out  NREQ  one-hot owner of the current job; 0 when idle.
REQ-012 row_data_o  out  WIDTH  row word to the array shift register.
REQ-013 row_v_o  out  1  array row-shift enable.
REQ-014 col_en_o  out  DIM  one-hot column latch enable.
REQ-015 busy_o  out  1  high in every state except IDLE.
REQ-016 done_o  out  NREQ  one-cycle job-complete pulse to the owner.
REQ-017 err_o  out  1  one-cycle timeout-abort pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, COLEN, COMPUTE, DONE and, only under the macro, ABORT.
REQ-019 In IDLE, if any req_v_i bit is set, the round-robin arbiter SHALL choose the first requesting index at or after rr_ptr, latch it into grant, and enter LOAD on the next edge; no word is consumed in IDLE.
REQ-020 In LOAD, req_r_o[grant] SHALL be 1 while word_cnt<DIM; all other ready bits SHALL be 0.
REQ-021 A handshake (req_v_i&req_r_o of the owner) SHALL drive row_v_o=1 and row_data_o=owner data combinationally (zero latency) and SHALL increment word_cnt.
REQ-022 The handshake that brings word_cnt to DIM SHALL move the FSM to COLEN on the next edge.
REQ-023 COLEN SHALL last exactly one cycle with col_en_o = 1<<col_cnt and ready=0; it SHALL then increment col_cnt and clear word_cnt.
REQ-024 After COLEN, the FSM SHALL return to LOAD if col_cnt<DIM-1 before the increment, else enter COMPUTE.
REQ-025 COMPUTE SHALL last exactly COMPUTE_CYC cycles, counted by cyc_cnt.
REQ-026 DONE SHALL last one cycle with done_o[grant]=1, set rr_ptr=(grant+1) mod NREQ, clear grant, and go to IDLE.
REQ-027 Job length SHALL be DIM*DIM handshakes plus DIM COLEN cycles; with zero stalls, done_o SHALL assert DIM*DIM+DIM+COMPUTE_CYC+1 cycles after the grant edge.
REQ-028 Requests from non-owners SHALL wait, and ownership SHALL NOT change mid-job.
REQ-029 When the owner drops req_v_i in LOAD, the FSM SHALL hold and no counter SHALL advance.
REQ-030 row_v_o and col_en_o SHALL never assert in the same cycle.
REQ-031 Counter widths SHALL be $clog2(DIM+1) for word/col counts and $clog2(COMPUTE_CYC+1) for cyc_cnt, with no wrap within a job.

Reset
REQ-032 While rst_ni=0, the block SHALL be in IDLE with all counters, grant, and rr_ptr at 0, and with every output at 0, including row_data_o.
REQ-033 Reset mid-job SHALL abandon the job immediately with no done_o pulse; the first job after reset SHALL start from rr_ptr=0.

Configuration
REQ-034 With SCHED_TIMEOUT_EN defined, stall_cnt SHALL count consecutive LOAD cycles without a handshake; on reaching TIMEOUT the FSM SHALL enter ABORT for one cycle (err_o=1, grant cleared, rr_ptr=(grant+1) mod NREQ), then enter IDLE, with no done_o pulse.
REQ-035 Without SCHED_TIMEOUT_EN, LOAD SHALL wait indefinitely, err_o SHALL be tied 0, and no ABORT state or stall_cnt SHALL exist.

Structure
REQ-036 The shared package matrix_pkg SHALL hold the DIM and WIDTH defaults and the sched_state_e enum.
REQ-037 Arbitration SHALL be implemented in the sub-module rr_arbiter (NREQ-wide req/ptr in, one-hot gnt out, purely combinational); the FSM and counters SHALL stay in matrix_load_sched.

Verification
REQ-038 Single job: with req0 streaming 16 words back-to-back, the bench SHALL see 16 row_v_o pulses, col_en_o sequence 0001,0010,0100,1000, and done_o=01 at cycle 29 after grant.
REQ-039 Contention: with req0 and req1 asserted together at reset exit, the bench SHALL see grant 01 first, then 10, then 01 again if req0 persists.
REQ-040 Stall: with req0 dropping valid for 5 cycles after word 6, the bench SHALL see word_cnt hold, no col_en_o, and done_o delayed by exactly 5 cycles.
REQ-041 Reset mid-job: with rst_ni low during COMPUTE, all outputs SHALL go 0 asynchronously, no done_o SHALL occur, and the next request SHALL be granted normally.
REQ-042 Timeout (macro on, TIMEOUT=64): with the owner silent for 64 cycles in LOAD, the bench SHALL see an err_o pulse, grant=0 the next cycle, and the other requester granted next.
REQ-043 Non-owner isolation: with req1 holding valid during a req0 job, the bench SHALL see req_r_o[1]=0 throughout and req1's data never appear on row_data_o.
